sic_ecr_requester: RTL and testbench

// Per-SIC requester side of the ECR lock/read/write/release protocol. Takes one acquisition
// (read/write masks + issue id) from its SIC, drives req/issue_id to every ECR, collects grants,

---
 rtl/sic_ecr_requester_if.sv | 34 +++
 rtl/sic_ecr_requester.sv | 175 +++++++++++++++++
 tb/tb_sic_ecr_requester.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sic_ecr_requester_if.sv
// ECR-side bus of one requester: per-lane lock requests, issue ids, releases and
// write-back data towards the ECR file, plus grants and current values coming back.
interface sic_ecr_requester_if #(
    parameter int NUM_ECRS = 4,
    parameter int ID_WIDTH = 4
);
    logic [NUM_ECRS-1:0]               ecr_req_read;
    logic [NUM_ECRS-1:0]               ecr_req_write;
    logic [NUM_ECRS-1:0][ID_WIDTH-1:0] ecr_issue_id;
    logic [NUM_ECRS-1:0]               ecr_release;
    logic [NUM_ECRS-1:0][1:0]          ecr_wdata;
    logic [NUM_ECRS-1:0]               ecr_grant;
    logic [NUM_ECRS-1:0][1:0]          ecr_rdata;

    modport master (
        output ecr_req_read,
        output ecr_req_write,
        output ecr_issue_id,
        output ecr_release,
        output ecr_wdata,
        input  ecr_grant,
        input  ecr_rdata
    );

    modport slave (
        input  ecr_req_read,
        input  ecr_req_write,
        input  ecr_issue_id,
        input  ecr_release,
        input  ecr_wdata,
        output ecr_grant,
        output ecr_rdata
    );
endinterface

// File: rtl/sic_ecr_requester.sv
// Per-SIC requester for the ECR lock/read/write/release protocol: acquires the requested
// lanes, snapshots their values for the SIC, then releases them with a one-cycle pulse.
module sic_ecr_requester #(
    parameter int NUM_ECRS       = 4,
    parameter int ID_WIDTH       = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_valid,
    output logic                         start_ready,
    input  logic [NUM_ECRS-1:0]          start_read_mask,
    input  logic [NUM_ECRS-1:0]          start_write_mask,
    input  logic [ID_WIDTH-1:0]          start_issue_id,
    output logic                         acq_done,
    output logic [NUM_ECRS-1:0][1:0]     acq_rdata,
    input  logic                         commit_valid,
    input  logic [NUM_ECRS-1:0][1:0]     commit_wdata,
    input  logic                         abort,
    output logic                         timeout,
    output logic                         busy,
    sic_ecr_requester_if.master          ecr
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t                     state_reg, state_next;
    logic [NUM_ECRS-1:0]        rmask_reg, rmask_next;
    logic [NUM_ECRS-1:0]        wmask_reg, wmask_next;
    logic [NUM_ECRS-1:0]        granted_reg, granted_next;
    logic [ID_WIDTH-1:0]        id_reg, id_next;
    logic [NUM_ECRS-1:0][1:0]   rdata_reg, rdata_next;
    logic [NUM_ECRS-1:0][1:0]   wdata_reg, wdata_next;
    logic [CNT_W-1:0]           count_reg, count_next;

    logic [NUM_ECRS-1:0]        first_grant;
    logic [NUM_ECRS-1:0][1:0]   rdata_capture;
    logic [NUM_ECRS-1:0]        lane_active;
    logic [NUM_ECRS-1:0]        release_lanes;
    logic                       all_granted;

    // A lane's value is sampled only on its first grant; later grant toggles are ignored.
    assign first_grant = ecr.ecr_grant & rmask_reg & ~granted_reg;
    assign all_granted = (((granted_reg | ecr.ecr_grant) & rmask_reg) == rmask_reg);

    generate
        for (genvar gi = 0; gi < NUM_ECRS; gi++) begin : g_capture
            assign rdata_capture[gi] = first_grant[gi] ? ecr.ecr_rdata[gi] : rdata_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        rmask_next   = rmask_reg;
        wmask_next   = wmask_reg;
        granted_next = granted_reg;
        id_next      = id_reg;
        rdata_next   = rdata_reg;
        wdata_next   = wdata_reg;

        case (state_reg)
            IDLE: begin
                if (start_valid) begin
                    wmask_next   = start_write_mask;
                    rmask_next   = start_read_mask | start_write_mask;
                    id_next      = start_issue_id;
                    granted_next = '0;
                    rdata_next   = '0;
                    wdata_next   = '0;
                    state_next   = ACQUIRE;
                end
            end
            ACQUIRE: begin
                granted_next = granted_reg | (ecr.ecr_grant & rmask_reg);
                rdata_next   = rdata_capture;
                if (abort) begin
                    // Write lanes granted so far hand back the value they read.
                    wdata_next = rdata_capture;
                    state_next = RELEASE;
                end else if (all_granted) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (abort) begin
                    wdata_next = rdata_reg;
                    state_next = RELEASE;
                end else if (commit_valid) begin
                    wdata_next = commit_wdata;
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                rmask_next   = '0;
                wmask_next   = '0;
                granted_next = '0;
                id_next      = '0;
                wdata_next   = '0;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Counter tracks ACQUIRE cycles including the current one, so timeout rises on
    // the TIMEOUT_CYCLES-th cycle spent waiting.
    always_comb begin
        count_next = '0;
        if (state_next == ACQUIRE) begin
            count_next = (count_reg == CNT_MAX) ? count_reg : count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            rmask_reg   <= '0;
            wmask_reg   <= '0;
            granted_reg <= '0;
            id_reg      <= '0;
            rdata_reg   <= '0;
            wdata_reg   <= '0;
            count_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            rmask_reg   <= rmask_next;
            wmask_reg   <= wmask_next;
            granted_reg <= granted_next;
            id_reg      <= id_next;
            rdata_reg   <= rdata_next;
            wdata_reg   <= wdata_next;
            count_reg   <= count_next;
        end
    end

    // During RELEASE only lanes actually held stay asserted; on an abort this drops
    // requests for lanes that were never granted.
    always_comb begin
        lane_active   = '0;
        release_lanes = '0;
        case (state_reg)
            ACQUIRE, HOLD: lane_active = rmask_reg;
            RELEASE: begin
                lane_active   = rmask_reg & granted_reg;
                release_lanes = rmask_reg & granted_reg;
            end
            default: ;
        endcase
    end

    generate
        for (genvar gi = 0; gi < NUM_ECRS; gi++) begin : g_lane
            assign ecr.ecr_req_write[gi] = lane_active[gi] & wmask_reg[gi];
            assign ecr.ecr_req_read[gi]  = lane_active[gi] & ~wmask_reg[gi];
            assign ecr.ecr_issue_id[gi]  = lane_active[gi] ? id_reg : '0;
            assign ecr.ecr_release[gi]   = release_lanes[gi];
            assign ecr.ecr_wdata[gi]     = (release_lanes[gi] & wmask_reg[gi]) ? wdata_reg[gi] : 2'b00;
        end
    endgenerate

    assign start_ready = (state_reg == IDLE);
    assign busy        = (state_reg != IDLE);
    assign acq_done    = (state_reg == HOLD);
    assign acq_rdata   = rdata_reg;
    assign timeout     = (state_reg == ACQUIRE) && (count_reg == CNT_MAX);

endmodule

// File: tb/tb_sic_ecr_requester.sv
// Directed bench for sic_ecr_requester: acquire/commit, partial grants, abort,
// timeout, abort-over-commit and asynchronous reset, with hand-computed expectations.
module tb_sic_ecr_requester;

    localparam int NUM_ECRS = 4;
    localparam int ID_WIDTH = 4;

    logic clk;
    logic rst_n;
    logic start_valid;
    logic start_ready;
    logic [NUM_ECRS-1:0] start_read_mask;
    logic [NUM_ECRS-1:0] start_write_mask;
    logic [ID_WIDTH-1:0] start_issue_id;
    logic acq_done;
    logic [NUM_ECRS-1:0][1:0] acq_rdata;
    logic commit_valid;
    logic [NUM_ECRS-1:0][1:0] commit_wdata;
    logic abort;
    logic timeout;
    logic busy;

    int n_vec = 0;
    int n_err = 0;

    sic_ecr_requester_if #(.NUM_ECRS(NUM_ECRS), .ID_WIDTH(ID_WIDTH)) ecr_bus ();

    sic_ecr_requester #(
        .NUM_ECRS(NUM_ECRS),
        .ID_WIDTH(ID_WIDTH),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .start_read_mask(start_read_mask),
        .start_write_mask(start_write_mask),
        .start_issue_id(start_issue_id),
        .acq_done(acq_done),
        .acq_rdata(acq_rdata),
        .commit_valid(commit_valid),
        .commit_wdata(commit_wdata),
        .abort(abort),
        .timeout(timeout),
        .busy(busy),
        .ecr(ecr_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge, away from the active edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start(input logic [3:0] rm, input logic [3:0] wm, input logic [3:0] id);
        start_valid      = 1'b1;
        start_read_mask  = rm;
        start_write_mask = wm;
        start_issue_id   = id;
        tick();
        start_valid      = 1'b0;
        start_read_mask  = '0;
        start_write_mask = '0;
        start_issue_id   = '0;
    endtask

    initial begin
        rst_n            = 1'b0;
        start_valid      = 1'b0;
        start_read_mask  = '0;
        start_write_mask = '0;
        start_issue_id   = '0;
        commit_valid     = 1'b0;
        commit_wdata     = '0;
        abort            = 1'b0;
        ecr_bus.ecr_grant = '0;
        ecr_bus.ecr_rdata = '0;

        @(negedge clk);
        @(negedge clk);
        check("rst_start_ready", 64'(start_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_req_read", 64'(ecr_bus.ecr_req_read), 64'd0);
        check("rst_release", 64'(ecr_bus.ecr_release), 64'd0);
        rst_n = 1'b1;
        tick();
        $display("reset released: start_ready=%0d busy=%0d", start_ready, busy);

        // 1: single read lane granted on the third ACQUIRE cycle
        start(4'b0001, 4'b0000, 4'h5);
        check("t1_start_ready", 64'(start_ready), 64'd0);
        check("t1_req_read", 64'(ecr_bus.ecr_req_read), 64'h1);
        check("t1_req_write", 64'(ecr_bus.ecr_req_write), 64'h0);
        check("t1_issue_id", 64'(ecr_bus.ecr_issue_id), 64'h0005);
        tick();
        tick();
        ecr_bus.ecr_grant = 4'b0001;
        ecr_bus.ecr_rdata = 8'h02;
        check("t1_done_c3", 64'(acq_done), 64'd0);
        tick();
        ecr_bus.ecr_grant = '0;
        ecr_bus.ecr_rdata = '0;
        check("t1_done_hold", 64'(acq_done), 64'd1);
        check("t1_acq_rdata", 64'(acq_rdata), 64'h02);
        commit_valid = 1'b1;
        tick();
        commit_valid = 1'b0;
        check("t1_release", 64'(ecr_bus.ecr_release), 64'h1);
        check("t1_wdata", 64'(ecr_bus.ecr_wdata), 64'h00);
        tick();
        check("t1_release_end", 64'(ecr_bus.ecr_release), 64'h0);
        check("t1_idle_ready", 64'(start_ready), 64'd1);
        $display("txn1 read lane0: acq_rdata=%0h", acq_rdata);

        // 2: two write lanes granted at different cycles, then commit
        start(4'b0000, 4'b0110, 4'h3);
        ecr_bus.ecr_grant = 4'b0010;
        ecr_bus.ecr_rdata = 8'h24;
        check("t2_req_write", 64'(ecr_bus.ecr_req_write), 64'h6);
        check("t2_req_read", 64'(ecr_bus.ecr_req_read), 64'h0);
        check("t2_issue_id", 64'(ecr_bus.ecr_issue_id), 64'h0330);
        tick();
        ecr_bus.ecr_grant = '0;
        check("t2_done_c2", 64'(acq_done), 64'd0);
        tick();
        tick();
        ecr_bus.ecr_grant = 4'b0100;
        ecr_bus.ecr_rdata = 8'h2C;
        tick();
        ecr_bus.ecr_grant = '0;
        ecr_bus.ecr_rdata = '0;
        check("t2_done_hold", 64'(acq_done), 64'd1);
        check("t2_acq_rdata", 64'(acq_rdata), 64'h24);
        commit_valid = 1'b1;
        commit_wdata = 8'hFF;
        tick();
        commit_valid = 1'b0;
        commit_wdata = '0;
        check("t2_release", 64'(ecr_bus.ecr_release), 64'h6);
        check("t2_wdata", 64'(ecr_bus.ecr_wdata), 64'h3C);
        tick();
        check("t2_wdata_idle", 64'(ecr_bus.ecr_wdata), 64'h00);
        $display("txn2 write lanes1,2: committed wdata 3 to both");

        // 3: abort with only one of two lanes granted
        start(4'b0011, 4'b0000, 4'h9);
        ecr_bus.ecr_grant = 4'b0001;
        ecr_bus.ecr_rdata = 8'h03;
        tick();
        ecr_bus.ecr_grant = '0;
        ecr_bus.ecr_rdata = '0;
        abort = 1'b1;
        check("t3_done_c2", 64'(acq_done), 64'd0);
        tick();
        abort = 1'b0;
        check("t3_release", 64'(ecr_bus.ecr_release), 64'h1);
        check("t3_req_read", 64'(ecr_bus.ecr_req_read), 64'h1);
        check("t3_issue_id", 64'(ecr_bus.ecr_issue_id), 64'h0009);
        tick();
        check("t3_idle_busy", 64'(busy), 64'd0);
        check("t3_idle_req", 64'(ecr_bus.ecr_req_read), 64'h0);
        $display("txn3 abort: lane0 released, lane1 dropped");

        // 4: no grants; timeout from the fourth ACQUIRE cycle until abort
        start(4'b0100, 4'b0000, 4'h1);
        check("t4_to_c1", 64'(timeout), 64'd0);
        start_valid     = 1'b1;
        start_read_mask = 4'b1000;
        tick();
        start_valid     = 1'b0;
        start_read_mask = '0;
        check("t4_start_ignored", 64'(ecr_bus.ecr_req_read), 64'h4);
        tick();
        check("t4_to_c3", 64'(timeout), 64'd0);
        tick();
        check("t4_to_c4", 64'(timeout), 64'd1);
        tick();
        tick();
        check("t4_to_c6", 64'(timeout), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_to_release", 64'(timeout), 64'd0);
        check("t4_release", 64'(ecr_bus.ecr_release), 64'h0);
        tick();
        $display("txn4 timeout: aborted after saturation");

        // 5: abort beats commit in the same HOLD cycle; write lane returns captured value
        start(4'b0000, 4'b1000, 4'h7);
        ecr_bus.ecr_grant = 4'b1000;
        ecr_bus.ecr_rdata = 8'h40;
        tick();
        ecr_bus.ecr_grant = '0;
        ecr_bus.ecr_rdata = '0;
        check("t5_acq_rdata", 64'(acq_rdata), 64'h40);
        commit_valid = 1'b1;
        abort        = 1'b1;
        commit_wdata = 8'hC0;
        tick();
        commit_valid = 1'b0;
        abort        = 1'b0;
        commit_wdata = '0;
        check("t5_release", 64'(ecr_bus.ecr_release), 64'h8);
        check("t5_wdata", 64'(ecr_bus.ecr_wdata), 64'h40);
        check("t5_req_write", 64'(ecr_bus.ecr_req_write), 64'h8);
        tick();
        $display("txn5 abort+commit: wrote back captured value");

        // 6: asynchronous reset while holding a write lock
        start(4'b0001, 4'b0001, 4'h2);
        ecr_bus.ecr_grant = 4'b0001;
        tick();
        ecr_bus.ecr_grant = '0;
        check("t6_hold", 64'(acq_done), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_req_write", 64'(ecr_bus.ecr_req_write), 64'h0);
        check("t6_rst_issue_id", 64'(ecr_bus.ecr_issue_id), 64'h0);
        check("t6_rst_done", 64'(acq_done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("t6_ready_after", 64'(start_ready), 64'd1);
        check("t6_busy_after", 64'(busy), 64'd0);
        $display("txn6 async reset in HOLD: outputs cleared");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
